// File: rtl/gba_wave_ram_arb_pkg.sv
// Shared sound-block definitions for the wave-RAM arbiter: FSM encoding,
// address/lane decode widths and the playback address decode.
package gba_wave_ram_arb_pkg;

  localparam int unsigned PTR_W  = 6;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    PLAY_ADDR,
    PLAY_DATA,
    CPU_WR,
    CPU_ADDR,
    CPU_DATA
  } arb_state_t;

  // In 64-sample mode the top pointer bit walks across both banks.
  function automatic logic [ADDR_W-1:0] play_addr(input logic [2:0] ptr_hi,
                                                  input logic       bank,
                                                  input logic       dim);
    logic b;
    b = dim ? (bank ^ ptr_hi[2]) : bank;
    return {b, ptr_hi[1:0]};
  endfunction

endpackage

// File: rtl/gba_wave_nibble_sel.sv
// Picks one 4-bit sample out of a 32-bit wave-RAM word: byte lane 0 is
// bits [7:0]; the even sample of each byte is its high nibble.
module gba_wave_nibble_sel
  import gba_wave_ram_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [LANE_W-1:0] i_lane,
  input  logic              i_lo,
  output logic [NIB_W-1:0]  o_nibble
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = '0;
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    o_nibble = i_lo ? w_byte[3:0] : w_byte[7:4];
  end

endmodule

// File: rtl/gba_wave_ram_arb.sv
// Wave-RAM arbiter: shares one 8x32 single-port RAM between sample playback
// and CPU word accesses, with bounded CPU starvation.
module gba_wave_ram_arb
  import gba_wave_ram_arb_pkg::*;
#(
  parameter int unsigned CPU_MAX_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              gb_on,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_word,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              bank_play,
  input  logic              dim,
  input  logic              play_req,
  input  logic [PTR_W-1:0]  play_ptr,
  output logic              play_ack,
  output logic [NIB_W-1:0]  play_nibble,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [BE_W-1:0]   ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned WAIT_W = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  arb_state_t r_state, w_next;

  logic [WAIT_W-1:0] r_wait;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_bank;
  logic              r_dim;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;
  logic              r_play_ack;
  logic [NIB_W-1:0]  r_nibble;

  logic              w_idle;
  logic              w_grant_play;
  logic              w_grant_cpu;
  logic [NIB_W-1:0]  w_nibble;

  assign w_idle       = (r_state == IDLE) && gb_on;
  assign w_grant_play = w_idle && play_req && (!cpu_req || (r_wait < WAIT_MAX));
  assign w_grant_cpu  = w_idle && !w_grant_play && cpu_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_play)     w_next = PLAY_ADDR;
        else if (w_grant_cpu) w_next = cpu_we ? CPU_WR : CPU_ADDR;
      end
      PLAY_ADDR: w_next = PLAY_DATA;
      PLAY_DATA: w_next = IDLE;
      CPU_WR:    w_next = IDLE;
      CPU_ADDR:  w_next = CPU_DATA;
      CPU_DATA:  w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (!gb_on) w_next = IDLE;
  end

  gba_wave_nibble_sel u_nibble_sel (
    .i_word   (ram_rdata),
    .i_lane   (r_ptr[2:1]),
    .i_lo     (r_ptr[0]),
    .o_nibble (w_nibble)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait      <= '0;
      r_ptr       <= '0;
      r_bank      <= 1'b0;
      r_dim       <= 1'b0;
      r_cpu_addr  <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_play_ack  <= 1'b0;
      r_nibble    <= '0;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_play_ack <= 1'b0;
      if (!gb_on) begin
        r_wait   <= '0;
        r_nibble <= '0;
      end else begin
        if (w_grant_play) begin
          r_ptr  <= play_ptr;
          r_bank <= bank_play;
          r_dim  <= dim;
          if (cpu_req) r_wait <= r_wait + WAIT_W'(1);
        end
        if (w_grant_cpu) begin
          r_wait     <= '0;
          r_cpu_addr <= {~bank_play, cpu_word};
          r_be       <= cpu_be;
          r_wdata    <= cpu_wdata;
        end
        if (r_state == PLAY_DATA) begin
          r_nibble   <= w_nibble;
          r_play_ack <= 1'b1;
        end
        if (r_state == CPU_DATA) begin
          r_cpu_rdata <= ram_rdata;
          r_cpu_ack   <= 1'b1;
        end
      end
    end
  end

  // RAM controls decode from the state so reset or flush drops them at once.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_be   = '0;
    case (r_state)
      PLAY_ADDR, PLAY_DATA: ram_addr = play_addr(r_ptr[5:3], r_bank, r_dim);
      CPU_WR: begin
        ram_addr = r_cpu_addr;
        ram_we   = gb_on;
        ram_be   = r_be;
      end
      CPU_ADDR, CPU_DATA: ram_addr = r_cpu_addr;
      default: ;
    endcase
  end

  assign ram_wdata   = r_wdata;
  assign cpu_ack     = gb_on & (r_cpu_ack | (r_state == CPU_WR));
  assign cpu_rdata   = r_cpu_rdata;
  assign play_ack    = gb_on & r_play_ack;
  assign play_nibble = r_nibble;

endmodule

// File: tb/tb_gba_wave_ram_arb.sv
// Directed bench for gba_wave_ram_arb with a behavioural 8x32 RAM
// (one-cycle read latency, byte-enabled writes).
module tb_gba_wave_ram_arb;
  import gba_wave_ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, gb_on;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_word;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        bank_play, dim, play_req;
  logic [5:0]  play_ptr;
  logic        play_ack;
  logic [3:0]  play_nibble;
  logic [2:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        tb_ld;
  logic [2:0]  tb_ld_addr;
  logic [31:0] tb_ld_data;
  logic [31:0] mem [8];
  logic [31:0] init_words [8] = '{32'h0000_00A5, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'hDEAD_BEEF,
                                  32'h0000_005A, 32'h1357_9BDF, 32'h1122_3344, 32'h2468_ACE0};

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_ld) mem[tb_ld_addr] <= tb_ld_data;
    else if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  gba_wave_ram_arb #(.CPU_MAX_WAIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .gb_on(gb_on),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_word(cpu_word), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .bank_play(bank_play), .dim(dim), .play_req(play_req), .play_ptr(play_ptr),
    .play_ack(play_ack), .play_nibble(play_nibble),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; gb_on = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_word = '0;
    cpu_wdata = '0; cpu_be = '0; bank_play = 1'b0; dim = 1'b0; play_req = 1'b0;
    play_ptr = '0; tb_ld = 1'b0; tb_ld_addr = '0; tb_ld_data = '0;
    for (int i = 0; i < 8; i++) begin
      tb_ld = 1'b1; tb_ld_addr = 3'(i); tb_ld_data = init_words[i];
      tick();
    end
    tb_ld = 1'b0;
    checks++;
    if ({cpu_ack, play_ack, ram_we} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {cpu_ack, play_ack, ram_we});
    end
    checks++;
    if ({ram_addr, ram_be, play_nibble} !== 11'd0) begin
      errors++; $display("FAIL reset_addr_be_nib: got %h expected 0", {ram_addr, ram_be, play_nibble});
    end
    checks++;
    if ({cpu_rdata, ram_wdata} !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, ram_wdata});
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_play_decode();
    logic [5:0] t_ptr  [7] = '{6'd9, 6'd10, 6'd15, 6'd32, 6'd32, 6'd0, 6'd63};
    logic       t_bank [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       t_dim  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       t_flip [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] t_addr [7] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd4, 3'd4, 3'd7};
    logic [3:0] t_nib  [7] = '{4'hF, 4'hC, 4'h9, 4'hA, 4'h5, 4'h5, 4'h4};
    for (int i = 0; i < 7; i++) begin
      play_req = 1'b1; play_ptr = t_ptr[i]; bank_play = t_bank[i]; dim = t_dim[i];
      tick();
      checks++;
      if (ram_addr !== t_addr[i] || ram_we !== 1'b0) begin
        errors++; $display("FAIL play_addr[%0d]: got addr %0d we %b expected addr %0d we 0",
                           i, ram_addr, ram_we, t_addr[i]);
      end
      play_req = 1'b0;
      // Bank moves after grant: the fetch must keep the grant-time bank.
      if (t_flip[i]) bank_play = ~bank_play;
      tick();
      checks++;
      if (play_ack !== 1'b0) begin
        errors++; $display("FAIL play_early_ack[%0d]: got %b expected 0", i, play_ack);
      end
      tick();
      checks++;
      if (play_ack !== 1'b1 || play_nibble !== t_nib[i]) begin
        errors++; $display("FAIL play_nibble[%0d]: got ack %b nib %h expected ack 1 nib %h",
                           i, play_ack, play_nibble, t_nib[i]);
      end
      tick();
      checks++;
      if (play_ack !== 1'b0) begin
        errors++; $display("FAIL play_ack_pulse[%0d]: got %b expected 0", i, play_ack);
      end
    end
  endtask

  task automatic test_priority();
    int seq [4];
    int n = 0;
    logic [31:0] rd = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 2'd0; bank_play = 1'b0; dim = 1'b0;
    play_req = 1'b1; play_ptr = 6'd9;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (play_ack && n < 4) begin seq[n] = 1; n++; end
      if (cpu_ack && n < 4) begin
        if (n == 1) rd = cpu_rdata;
        seq[n] = 2; n++;
      end
    end
    cpu_req = 1'b0; play_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL prio_count: got %0d grants expected 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seq[k] !== ((k % 2 == 0) ? 1 : 2)) begin
          errors++; $display("FAIL prio_order[%0d]: got %0d expected %0d (1=play 2=cpu)",
                             k, seq[k], (k % 2 == 0) ? 1 : 2);
        end
      end
      checks++;
      if (rd !== 32'h0000_005A) begin
        errors++; $display("FAIL prio_cpu_rdata: got %h expected 0000005a", rd);
      end
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int t [3];
    int n = 0;
    play_req = 1'b1; play_ptr = 6'd15; bank_play = 1'b0; dim = 1'b0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      tick();
      if (play_ack) begin
        t[n] = c; n++;
        checks++;
        if (play_nibble !== 4'h9) begin
          errors++; $display("FAIL b2b_nibble: got %h expected 9", play_nibble);
        end
      end
    end
    play_req = 1'b0;
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_count: got %0d acks expected 3", n);
    end else begin
      checks++;
      if (t[0] != 2 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
        errors++; $display("FAIL b2b_spacing: got ack cycles %0d %0d %0d expected 2 5 8",
                           t[0], t[1], t[2]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 2'd2; cpu_be = 4'b0100;
    cpu_wdata = 32'h0055_0000; bank_play = 1'b0;
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 3'd6 || ram_be !== 4'b0100 ||
        ram_wdata !== 32'h0055_0000 || cpu_ack !== 1'b1) begin
      errors++; $display("FAIL wr_cycle: got we %b addr %0d be %b wd %h ack %b expected 1 6 0100 00550000 1",
                         ram_we, ram_addr, ram_be, ram_wdata, cpu_ack);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (ram_we !== 1'b0 || ram_be !== 4'b0000 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL wr_one_cycle: got we %b be %b ack %b expected 0 0000 0",
                         ram_we, ram_be, cpu_ack);
    end
    checks++;
    if (mem[6] !== 32'h1155_3344) begin
      errors++; $display("FAIL wr_ram_word: got %h expected 11553344", mem[6]);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 2'd2;
    tick();
    checks++;
    if (ram_addr !== 3'd6 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL rd_addr: got addr %0d we %b ack %b expected 6 0 0", ram_addr, ram_we, cpu_ack);
    end
    cpu_req = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1155_3344) begin
      errors++; $display("FAIL rd_data: got ack %b data %h expected 1 11553344", cpu_ack, cpu_rdata);
    end
    checks++;
    if (cpu_rdata[23:16] !== 8'h55) begin
      errors++; $display("FAIL rd_byte2: got %h expected 55", cpu_rdata[23:16]);
    end
    tick();
  endtask

  task automatic test_gb_off();
    play_req = 1'b1; play_ptr = 6'd10; bank_play = 1'b0; dim = 1'b0;
    tick();
    play_req = 1'b0;
    tick();
    gb_on = 1'b0;
    tick();
    checks++;
    if (play_ack !== 1'b0 || play_nibble !== 4'h0) begin
      errors++; $display("FAIL gboff_flush: got ack %b nib %h expected 0 0", play_ack, play_nibble);
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++; $display("FAIL gboff_state: got %0d expected %0d", dut.r_state, IDLE);
    end
    play_req = 1'b1;
    tick();
    checks++;
    if (ram_addr !== 3'd0 || dut.r_state !== IDLE) begin
      errors++; $display("FAIL gboff_no_grant: got addr %0d state %0d expected 0 %0d",
                         ram_addr, dut.r_state, IDLE);
    end
    play_req = 1'b0; gb_on = 1'b1;
    tick();
    tick();
    checks++;
    if (play_ack !== 1'b0) begin
      errors++; $display("FAIL gboff_discard: got ack %b expected 0", play_ack);
    end
  endtask

  task automatic test_reset_mid_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 2'd3; cpu_be = 4'hF;
    cpu_wdata = 32'hCAFE_F00D; bank_play = 1'b1;
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 3'd3) begin
      errors++; $display("FAIL rst_pre_wr: got we %b addr %0d expected 1 3", ram_we, ram_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || cpu_ack !== 1'b0 || play_ack !== 1'b0) begin
      errors++; $display("FAIL rst_async_strobes: got we %b cack %b pack %b expected 0 0 0",
                         ram_we, cpu_ack, play_ack);
    end
    checks++;
    if (ram_addr !== 3'd0 || ram_be !== 4'd0 || ram_wdata !== 32'd0 ||
        cpu_rdata !== 32'd0 || play_nibble !== 4'd0) begin
      errors++; $display("FAIL rst_async_values: got addr %0d be %h wd %h rd %h nib %h expected all 0",
                         ram_addr, ram_be, ram_wdata, cpu_rdata, play_nibble);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (mem[3] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rst_no_partial_write: got %h expected deadbeef", mem[3]);
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_play_decode();
    test_priority();
    test_back_to_back();
    test_cpu_write_read();
    test_gb_off();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
